// File: rtl/mem_bus_arbiter.sv
// ============================================================================
// Module  : mem_bus_arbiter
// Brief   : Two-port round-robin arbiter and address/data mux for a
//           single-port memory, with hold limit and per-port read-valid.
// Revision: 1.0
// ============================================================================
`default_nettype none

module mem_bus_arbiter #(
  parameter int AWIDTH   = 5,
  parameter int DWIDTH   = 8,
  parameter int MAX_HOLD = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              we0,
  input  logic [AWIDTH-1:0] addr0,
  input  logic [DWIDTH-1:0] wdata0,
  output logic              gnt0,
  output logic              rvalid0,
  input  logic              req1,
  input  logic              we1,
  input  logic [AWIDTH-1:0] addr1,
  input  logic [DWIDTH-1:0] wdata1,
  output logic              gnt1,
  output logic              rvalid1,
  output logic [AWIDTH-1:0] mem_addr,
  output logic [DWIDTH-1:0] mem_wdata,
  output logic              mem_rd,
  output logic              mem_wr,
  input  logic [DWIDTH-1:0] mem_rdata,
  output logic [DWIDTH-1:0] rdata
);

  localparam int              HCW       = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HCW-1:0]  HOLD_LAST = HCW'(MAX_HOLD - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_G0   = 2'd1;
  localparam logic [1:0] S_G1   = 2'd2;

  logic [1:0]     state, state_nxt;
  logic [HCW-1:0] hold_cnt, hold_nxt;
  logic           last, last_nxt;
  logic           hold_done;

  assign hold_done = (hold_cnt == HOLD_LAST);

  // State register; read-valid tracks the strobe issued in the previous cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      hold_cnt <= '0;
      last     <= 1'b1;
      rvalid0  <= 1'b0;
      rvalid1  <= 1'b0;
    end else begin
      state    <= state_nxt;
      hold_cnt <= hold_nxt;
      last     <= last_nxt;
      rvalid0  <= gnt0 & req0 & ~we0;
      rvalid1  <= gnt1 & req1 & ~we1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (req0 && req1)  state_nxt = last ? S_G0 : S_G1;
        else if (req0)     state_nxt = S_G0;
        else if (req1)     state_nxt = S_G1;
      end
      S_G0: begin
        if (!req0)                 state_nxt = req1 ? S_G1 : S_IDLE;
        else if (req1 && hold_done) state_nxt = S_G1;
      end
      S_G1: begin
        if (!req1)                 state_nxt = req0 ? S_G0 : S_IDLE;
        else if (req0 && hold_done) state_nxt = S_G0;
      end
      default: state_nxt = S_IDLE;
    endcase

    // Counter keeps running while the other port is idle so a reached limit
    // forces a switch as soon as it starts requesting.
    hold_nxt = hold_cnt;
    if (state_nxt != state)
      hold_nxt = '0;
    else if (state != S_IDLE && !hold_done)
      hold_nxt = hold_cnt + 1'b1;

    last_nxt = last;
    if (state_nxt == S_G0 && state != S_G0) last_nxt = 1'b0;
    if (state_nxt == S_G1 && state != S_G1) last_nxt = 1'b1;
  end

  always_comb begin
    gnt0      = (state == S_G0);
    gnt1      = (state == S_G1);
    mem_rd    = (gnt0 & req0 & ~we0) | (gnt1 & req1 & ~we1);
    mem_wr    = (gnt0 & req0 &  we0) | (gnt1 & req1 &  we1);
    mem_addr  = '0;
    mem_wdata = '0;
    if (gnt0) begin
      mem_addr  = addr0;
      mem_wdata = wdata0;
    end else if (gnt1) begin
      mem_addr  = addr1;
      mem_wdata = wdata1;
    end
    rdata = mem_rdata;
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_bus_arbiter.sv
// ============================================================================
// Module  : tb_mem_bus_arbiter
// Brief   : Vector table plus read-data scoreboard bench for mem_bus_arbiter.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_mem_bus_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0, we0, req1, we1;
  logic [4:0] addr0, addr1;
  logic [7:0] wdata0, wdata1;
  logic       gnt0, gnt1, rvalid0, rvalid1, mem_rd, mem_wr;
  logic [4:0] mem_addr;
  logic [7:0] mem_wdata, mem_rdata, rdata;

  logic       a_gnt0, a_gnt1, a_rvalid0, a_rvalid1, a_mem_rd, a_mem_wr;
  logic [4:0] a_mem_addr;
  logic [7:0] a_mem_wdata, a_rdata;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.AWIDTH(5), .DWIDTH(8), .MAX_HOLD(8)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .gnt0(gnt0), .rvalid0(rvalid0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .gnt1(gnt1), .rvalid1(rvalid1),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_rdata(mem_rdata), .rdata(rdata)
  );

  mem_bus_arbiter #(.AWIDTH(5), .DWIDTH(8), .MAX_HOLD(1)) dut_alt (
    .clk(clk), .rst(rst),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .gnt0(a_gnt0), .rvalid0(a_rvalid0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .gnt1(a_gnt1), .rvalid1(a_rvalid1),
    .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata), .mem_rd(a_mem_rd), .mem_wr(a_mem_wr),
    .mem_rdata(mem_rdata), .rdata(a_rdata)
  );

  typedef struct {
    logic       r0, w0;
    logic [4:0] a0;
    logic [7:0] d0;
    logic       r1, w1;
    logic [4:0] a1;
    logic [7:0] d1;
    logic       g0, g1, full, rd, wr;
    logic [4:0] ea;
    logic [7:0] ed;
  } vec_t;

  typedef struct {
    bit         port;
    logic [7:0] data;
    int         due;
  } sb_t;

  sb_t        sb[$];
  logic [7:0] mem     [32];
  logic [7:0] ref_mem [32];
  vec_t       tbl     [13];
  int         errors = 0;
  int         checks = 0;
  int         cyc    = 0;

  // Memory with one-cycle read latency
  always @(posedge clk) begin
    if (mem_wr) mem[mem_addr] <= mem_wdata;
    if (mem_rd) mem_rdata <= mem[mem_addr];
  end

  function automatic logic [7:0] init_byte(input int i);
    return (i == 10) ? 8'h3C : 8'((i * 37 + 11) ^ 8'h5A);
  endfunction

  function automatic vec_t mk(input logic r0, w0, input logic [4:0] a0, input logic [7:0] d0,
                              input logic r1, w1, input logic [4:0] a1, input logic [7:0] d1,
                              input logic g0, g1, full, rd, wr,
                              input logic [4:0] ea, input logic [7:0] ed);
    vec_t v;
    v.r0 = r0; v.w0 = w0; v.a0 = a0; v.d0 = d0;
    v.r1 = r1; v.w1 = w1; v.a1 = a1; v.d1 = d1;
    v.g0 = g0; v.g1 = g1; v.full = full; v.rd = rd; v.wr = wr;
    v.ea = ea; v.ed = ed;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic sb_check();
    sb_t e;
    bit  e0 = 1'b0;
    bit  e1 = 1'b0;
    while (sb.size() > 0 && sb[0].due < cyc) begin
      chk("sb_stale", 32'(sb[0].due), 32'(cyc));
      void'(sb.pop_front());
    end
    if (sb.size() > 0 && sb[0].due == cyc) begin
      e  = sb.pop_front();
      e0 = (e.port == 1'b0);
      e1 = (e.port == 1'b1);
      chk("rdata", rdata, e.data);
    end
    chk("rvalid0", rvalid0, e0);
    chk("rvalid1", rvalid1, e1);
  endtask

  task automatic run_vec(input vec_t v);
    @(posedge clk);
    #1;
    cyc++;
    req0 = v.r0; we0 = v.w0; addr0 = v.a0; wdata0 = v.d0;
    req1 = v.r1; we1 = v.w1; addr1 = v.a1; wdata1 = v.d1;
    if (v.g0 && v.r0) begin
      if (v.w0) ref_mem[v.a0] = v.d0;
      else      sb.push_back('{port: 1'b0, data: ref_mem[v.a0], due: cyc + 1});
    end
    if (v.g1 && v.r1) begin
      if (v.w1) ref_mem[v.a1] = v.d1;
      else      sb.push_back('{port: 1'b1, data: ref_mem[v.a1], due: cyc + 1});
    end
    @(negedge clk);
    chk("gnt0", gnt0, v.g0);
    chk("gnt1", gnt1, v.g1);
    chk("gnt_excl", gnt0 & gnt1, 0);
    if (v.full) begin
      chk("mem_rd", mem_rd, v.rd);
      chk("mem_wr", mem_wr, v.wr);
      chk("mem_addr", mem_addr, v.ea);
      chk("mem_wdata", mem_wdata, v.ed);
    end
    sb_check();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic e0, e1;
    for (int i = 0; i < 32; i++) begin
      mem[i]     = init_byte(i);
      ref_mem[i] = init_byte(i);
    end
    //             r0 w0 a0    d0    r1 w1 a1    d1     g0 g1 f rd wr ea    ed
    tbl[0]  = mk(1, 0, 5'h0A, 8'h00, 0, 0, 5'h00, 8'h00, 0, 0, 1, 0, 0, 5'h00, 8'h00);
    tbl[1]  = mk(1, 0, 5'h0A, 8'h00, 0, 0, 5'h00, 8'h00, 1, 0, 1, 1, 0, 5'h0A, 8'h00);
    tbl[2]  = mk(0, 0, 5'h0A, 8'h00, 1, 0, 5'h03, 8'h00, 1, 0, 1, 0, 0, 5'h0A, 8'h00);
    tbl[3]  = mk(0, 0, 5'h0A, 8'h00, 1, 0, 5'h03, 8'h00, 0, 1, 1, 1, 0, 5'h03, 8'h00);
    tbl[4]  = mk(0, 0, 5'h0A, 8'h00, 1, 1, 5'h1F, 8'hA5, 0, 1, 1, 0, 1, 5'h1F, 8'hA5);
    tbl[5]  = mk(1, 0, 5'h1F, 8'h00, 0, 1, 5'h1F, 8'hA5, 0, 1, 1, 0, 0, 5'h1F, 8'hA5);
    tbl[6]  = mk(1, 0, 5'h1F, 8'h00, 0, 1, 5'h1F, 8'hA5, 1, 0, 1, 1, 0, 5'h1F, 8'h00);
    tbl[7]  = mk(0, 0, 5'h1F, 8'h00, 0, 0, 5'h1F, 8'hA5, 1, 0, 1, 0, 0, 5'h1F, 8'h00);
    tbl[8]  = mk(1, 0, 5'h02, 8'h00, 1, 0, 5'h04, 8'h00, 0, 0, 1, 0, 0, 5'h00, 8'h00);
    tbl[9]  = mk(1, 0, 5'h02, 8'h00, 1, 0, 5'h04, 8'h00, 0, 1, 1, 1, 0, 5'h04, 8'h00);
    tbl[10] = mk(1, 0, 5'h02, 8'h00, 0, 0, 5'h04, 8'h00, 0, 1, 1, 0, 0, 5'h04, 8'h00);
    tbl[11] = mk(0, 0, 5'h02, 8'h00, 0, 0, 5'h04, 8'h00, 1, 0, 1, 0, 0, 5'h02, 8'h00);
    tbl[12] = mk(0, 0, 5'h00, 8'h00, 0, 0, 5'h00, 8'h00, 0, 0, 1, 0, 0, 5'h00, 8'h00);

    // Reset asserted with both ports requesting
    rst = 1'b0;
    req0 = 1'b1; we0 = 1'b0; addr0 = 5'h00; wdata0 = 8'h00;
    req1 = 1'b1; we1 = 1'b0; addr1 = 5'h00; wdata1 = 8'h00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_gnt0", gnt0, 0);
    chk("rst_gnt1", gnt1, 0);
    chk("rst_rvalid0", rvalid0, 0);
    chk("rst_rvalid1", rvalid1, 0);
    chk("rst_mem_rd", mem_rd, 0);
    chk("rst_mem_wr", mem_wr, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    // First tie after reset goes to port0; dropped request issues no access
    run_vec(mk(0, 0, 5'h00, 8'h00, 0, 0, 5'h00, 8'h00, 1, 0, 1, 0, 0, 5'h00, 8'h00));

    for (int i = 0; i < 13; i++) run_vec(tbl[i]);

    // Continuous contention: 8-cycle bursts here, strict alternation at MAX_HOLD=1
    for (int c = 0; c <= 32; c++) begin
      if (c == 0) begin
        e0 = 1'b0; e1 = 1'b0;
      end else begin
        e1 = (((c - 1) / 8) % 2) == 0;
        e0 = !e1;
      end
      run_vec(mk(1, 0, 5'h07, 8'h00, 1, 0, 5'h08, 8'h00, e0, e1, 0, 0, 0, 5'h00, 8'h00));
      chk("alt_gnt1", a_gnt1, (c != 0) && (c % 2 == 1));
      chk("alt_gnt0", a_gnt0, (c != 0) && (c % 2 == 0));
    end
    run_vec(mk(0, 0, 5'h07, 8'h00, 0, 0, 5'h08, 8'h00, 0, 1, 0, 0, 0, 5'h00, 8'h00));
    run_vec(mk(0, 0, 5'h07, 8'h00, 0, 0, 5'h08, 8'h00, 0, 0, 1, 0, 0, 5'h00, 8'h00));

    // Hold limit reached while port1 idle: switch on its first request cycle
    for (int c = 0; c <= 10; c++)
      run_vec(mk(1, 0, 5'h09, 8'h00, (c == 10), 0, 5'h0B, 8'h00,
                 (c != 0), 0, 0, 0, 0, 5'h00, 8'h00));
    run_vec(mk(0, 0, 5'h09, 8'h00, 0, 0, 5'h0B, 8'h00, 0, 1, 1, 0, 0, 5'h0B, 8'h00));
    run_vec(mk(0, 0, 5'h09, 8'h00, 0, 0, 5'h0B, 8'h00, 0, 0, 1, 0, 0, 5'h00, 8'h00));

    // Asynchronous reset in the middle of a port1 write
    run_vec(mk(0, 0, 5'h00, 8'h00, 1, 1, 5'h1E, 8'h5A, 0, 0, 1, 0, 0, 5'h00, 8'h00));
    @(posedge clk);
    #1;
    cyc++;
    #2;
    chk("g1wr_gnt1", gnt1, 1);
    chk("g1wr_mem_wr", mem_wr, 1);
    chk("g1wr_mem_addr", mem_addr, 5'h1E);
    chk("g1wr_mem_wdata", mem_wdata, 8'h5A);
    rst = 1'b0;
    #1;
    chk("arst_gnt0", gnt0, 0);
    chk("arst_gnt1", gnt1, 0);
    chk("arst_mem_wr", mem_wr, 0);
    chk("arst_mem_rd", mem_rd, 0);
    chk("arst_mem_addr", mem_addr, 0);
    chk("arst_rvalid0", rvalid0, 0);
    chk("arst_rvalid1", rvalid1, 0);
    req1 = 1'b0; we1 = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    run_vec(mk(1, 0, 5'h1E, 8'h00, 1, 0, 5'h1D, 8'h00, 0, 0, 1, 0, 0, 5'h00, 8'h00));
    run_vec(mk(1, 0, 5'h1E, 8'h00, 1, 0, 5'h1D, 8'h00, 1, 0, 1, 1, 0, 5'h1E, 8'h00));
    run_vec(mk(0, 0, 5'h1E, 8'h00, 0, 0, 5'h1D, 8'h00, 1, 0, 1, 0, 0, 5'h1E, 8'h00));
    run_vec(mk(0, 0, 5'h1E, 8'h00, 0, 0, 5'h1D, 8'h00, 0, 0, 1, 0, 0, 5'h00, 8'h00));
    chk("sb_empty", 32'(sb.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
